// File: rtl/sa_bitserial_ctrl.sv
// Bit-serial sequencer for one subarray MVM operation. A full activation
// vector is accepted, fed into the subarray MSB-first one bit-plane per
// cycle, then the controller waits out the subarray latency. It then captures
// the ADC result vector and presents it to the consumer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data until that edge. in_ready_o is
// high only in IDLE, and is dropped while abort_i is high. out_valid_o stays
// high with out_data_o stable until out_ready_i is seen or an abort occurs.
module sa_bitserial_ctrl #(
  parameter int N_ELEM_IN   = 256,
  parameter int N_ELEM_OUT  = 256,
  parameter int BIT_ADC     = 4,
  parameter int N_BIT_INPUT = 4,
  parameter int SA_LATENCY  = 2
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [N_ELEM_IN*N_BIT_INPUT-1:0] in_act_i,
  input  logic                            abort_i,
  output logic [N_ELEM_IN-1:0]            sa_bit_o,
  input  logic [N_ELEM_OUT*BIT_ADC-1:0]   sa_comp_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [N_ELEM_OUT*BIT_ADC-1:0]   out_data_o,
  output logic                            busy_o,
  output logic [15:0]                     op_count_o
);

  localparam int BW = $clog2(N_BIT_INPUT);
  localparam int LW = $clog2(SA_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                           state;
  logic [N_ELEM_IN*N_BIT_INPUT-1:0] act_q;
  logic [BW-1:0]                    bit_cnt;
  logic [LW-1:0]                    lat_cnt;

  logic [N_ELEM_IN*N_BIT_INPUT-1:0] plane_src;
  logic [BW-1:0]                    plane_idx;
  logic [N_BIT_INPUT-1:0]           src_elem [N_ELEM_IN];
  logic [N_ELEM_IN-1:0]             next_plane;

  // Ready only when idle; an abort in the same cycle blocks acceptance.
  assign in_ready_o = (state == S_IDLE) && !abort_i;
  assign busy_o     = (state != S_IDLE);

  // Bit-plane to present in the next cycle: the MSB of the incoming vector
  // when a vector is being accepted, otherwise the plane after bit_cnt.
  always_comb begin
    plane_src = act_q;
    plane_idx = BW'(N_BIT_INPUT - 2) - bit_cnt;
    if (state == S_IDLE) begin
      plane_src = in_act_i;
      plane_idx = BW'(N_BIT_INPUT - 1);
    end
    for (int k = 0; k < N_ELEM_IN; k++) begin
      src_elem[k]   = plane_src[k*N_BIT_INPUT +: N_BIT_INPUT];
      next_plane[k] = src_elem[k][plane_idx];
    end
  end

  // Operation sequencer with registered subarray and result outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      act_q       <= '0;
      bit_cnt     <= '0;
      lat_cnt     <= '0;
      sa_bit_o    <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      op_count_o  <= '0;
    end else if (abort_i && state != S_IDLE) begin
      // Abort drops the op; the last captured result is kept.
      state       <= S_IDLE;
      sa_bit_o    <= '0;
      out_valid_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid_i && in_ready_o) begin
            act_q    <= in_act_i;
            bit_cnt  <= '0;
            sa_bit_o <= next_plane;
            state    <= S_FEED;
          end
        end
        S_FEED: begin
          if (bit_cnt == BW'(N_BIT_INPUT - 1)) begin
            sa_bit_o <= '0;
            lat_cnt  <= '0;
            state    <= S_WAIT;
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            sa_bit_o <= next_plane;
          end
        end
        S_WAIT: begin
          if (lat_cnt == LW'(SA_LATENCY - 1)) begin
            out_data_o  <= sa_comp_i;
            out_valid_o <= 1'b1;
            state       <= S_OUT;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            op_count_o  <= op_count_o + 16'd1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_bitserial_ctrl.sv
// Bench for sa_bitserial_ctrl with four 4-bit rows/columns and a behavioural
// subarray model that rebuilds each row value from the MSB-first bit stream.
// It then outputs value+1 (mod 16) one register stage later.
module tb_sa_bitserial_ctrl;

  logic        clk;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_act;
  logic        abort;
  logic [3:0]  sa_bit;
  logic [15:0] sa_comp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic [15:0] op_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  sa_bitserial_ctrl #(
    .N_ELEM_IN(4), .N_ELEM_OUT(4), .BIT_ADC(4), .N_BIT_INPUT(4), .SA_LATENCY(2)
  ) dut (
    .clk(clk), .nrst(nrst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_act_i(in_act),
    .abort_i(abort), .sa_bit_o(sa_bit), .sa_comp_i(sa_comp),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .busy_o(busy), .op_count_o(op_count)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Subarray model: shift register per row, result registered once.
  logic [3:0] sh [4];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      sh[k] <= {sh[k][2:0], sa_bit[k]};
      sa_comp[k*4 +: 4] <= sh[k] + 4'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while ((busy || out_valid) && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard monitor: pops an expected result at every output handshake.
  always begin
    @(negedge clk);
    #2;
    if (nrst && out_valid && out_ready && !abort) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %0h required none", out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL sb_data: got %0h required %0h", out_data, e);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [15:0] acts [3];
    logic [15:0] exps [3];
    int          acc_cyc [3];
    int          n;
    int          seen;

    nrst = 1'b0; in_valid = 1'b0; in_act = '0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_sa_bit", {28'd0, sa_bit}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_count", {16'd0, op_count}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Reset in the middle of FEED discards the op.
    in_valid = 1'b1; in_act = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("midfeed_busy", {31'd0, busy}, 32'd1);
    nrst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_sa_bit", {28'd0, sa_bit}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_count", {16'd0, op_count}, 32'd0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Single op with cycle-exact timing.
    out_ready = 1'b1;
    in_valid = 1'b1; in_act = 16'h037B;
    exp_q.push_back(16'h148C);
    @(negedge clk);
    in_valid = 1'b0;
    chk("single_plane3", {28'd0, sa_bit}, 32'h1);
    chk("single_ready_feed", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("single_plane2", {28'd0, sa_bit}, 32'h2);
    @(negedge clk);
    chk("single_plane1", {28'd0, sa_bit}, 32'h7);
    @(negedge clk);
    chk("single_plane0", {28'd0, sa_bit}, 32'h7);
    @(negedge clk);
    chk("single_wait_sa_bit", {28'd0, sa_bit}, 32'd0);
    chk("single_wait_valid5", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("single_wait_valid6", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("single_valid7", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("single_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("single_ready_back", {31'd0, in_ready}, 32'd1);
    chk("single_count", {16'd0, op_count}, 32'd1);

    // Wrap: all-ones activations give zero results.
    in_valid = 1'b1; in_act = 16'hFFFF;
    exp_q.push_back(16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle("wrap_done");
    chk("wrap_count", {16'd0, op_count}, 32'd2);

    // Backpressure in OUT with a new vector waiting.
    out_ready = 1'b0;
    in_valid = 1'b1; in_act = 16'h1234;
    exp_q.push_back(16'h2345);
    @(negedge clk);
    in_act = 16'hAAAA;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", {16'd0, out_data}, 32'h2345);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    exp_q.push_back(16'hBBBB);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (in_ready) seen = 1;
    end
    chk("bp_accept_next", seen, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle("bp_done");
    chk("bp_count", {16'd0, op_count}, 32'd4);

    // Back-to-back ops with in_valid held high.
    acts[0] = 16'h5678; exps[0] = 16'h6789;
    acts[1] = 16'h0123; exps[1] = 16'h1234;
    acts[2] = 16'h9ABC; exps[2] = 16'hABCD;
    n = 0;
    in_valid = 1'b1; in_act = acts[0];
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (in_ready) begin
        exp_q.push_back(exps[n]);
        acc_cyc[n] = c;
        n++;
      end
      @(negedge clk);
      if (n < 3) in_act = acts[n];
    end
    in_valid = 1'b0;
    chk("b2b_accepts", n, 32'd3);
    if (n == 3) begin
      chk("b2b_period1", acc_cyc[1] - acc_cyc[0], 32'd8);
      chk("b2b_period2", acc_cyc[2] - acc_cyc[1], 32'd8);
    end
    wait_idle("b2b_done");
    chk("b2b_count", {16'd0, op_count}, 32'd7);

    // Abort in the second FEED cycle, then a clean op.
    in_valid = 1'b1; in_act = 16'h4321;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_plane2", {28'd0, sa_bit}, 32'h8);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sa_bit", {28'd0, sa_bit}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_count", {16'd0, op_count}, 32'd7);
    chk("abort_data_kept", {16'd0, out_data}, 32'hABCD);
    in_valid = 1'b1; in_act = 16'h8421;
    #1;
    chk("abort_blocks_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("abort_no_accept", {31'd0, busy}, 32'd0);
    abort = 1'b0;
    exp_q.push_back(16'h9532);
    #1;
    chk("post_abort_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_abort_busy", {31'd0, busy}, 32'd1);
    wait_idle("post_abort_done");
    chk("post_abort_count", {16'd0, op_count}, 32'd8);

    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
